mdu_sequencer: RTL and testbench

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

---
 rtl/mdu_sequencer_pkg.sv | 39 +++
 rtl/mdu_sequencer_arith.sv | 74 +++++++
 rtl/mdu_sequencer.sv | 123 ++++++++++++
 tb/tb_mdu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, latencies,
// FSM state type and small op-decode helpers.
// Optional feature macro: MDU_MADD_EN (enables the madd op, encoding 3'b100).
package mdu_sequencer_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic {StIdle, StBusy} state_e;

  // Ops the block accepts; anything else is silently ignored on start.
  function automatic logic op_valid(logic [2:0] op);
    logic v;
    unique case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: v = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD: v = 1'b1;
`endif
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Busy-cycle count loaded into the counter at issue.
  function automatic logic [CNT_W-1:0] op_lat(logic [2:0] op);
    logic [CNT_W-1:0] l;
    if (op == OP_DIV || op == OP_DIVU) l = CNT_W'(DIV_LAT);
    else                               l = CNT_W'(MULT_LAT);
    return l;
  endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// Combinational 64-bit arithmetic for the sequencer: computes next {hi,lo}
// from the latched operands, the latched op and the current hi/lo.
// Optional feature macro: MDU_MADD_EN (adds the multiply-accumulate path).
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_sdiv;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Products, plus a sign-magnitude divider so the most-negative / -1 case wraps cleanly.
  always_comb begin
    prod_s  = unsigned'($signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i}));
    prod_u  = {32'd0, a_i} * {32'd0, b_i};
    is_sdiv = (op_i == OP_DIV);
    neg_a   = is_sdiv & a_i[31];
    neg_b   = is_sdiv & b_i[31];
    mag_a   = neg_a ? (32'd0 - a_i) : a_i;
    mag_b   = neg_b ? (32'd0 - b_i) : b_i;
    // Keep the divider defined on a zero divisor; that result is discarded below.
    div_b   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    q_mag   = mag_a / div_b;
    r_mag   = mag_a % div_b;
    quot    = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
    rem     = neg_a ? (32'd0 - r_mag) : r_mag;
  end

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  // Accumulate the signed product onto the current {hi,lo}, wrapping mod 2^64.
  always_comb begin
    acc = {hi_i, lo_i} + prod_s;
  end
`endif

  // Select the result for the latched op; divide by zero keeps hi/lo as they are.
  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    unique case (op_i)
      OP_MULT:  {hi_o, lo_o} = prod_s;
      OP_MULTU: {hi_o, lo_o} = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_i != 32'd0) begin
          hi_o = rem;
          lo_o = quot;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_o, lo_o} = acc;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: fixed-latency IDLE/BUSY FSM owning HI/LO and the
// latched operands; the arithmetic itself lives in mdu_arith.
// Optional feature macro: MDU_MADD_EN (madd op accepted when defined).
module mdu_sequencer
  import mdu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, b_q;
  logic [2:0]       op_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      hi_res, lo_res;
  logic             load;
  logic             commit;
  logic             wr_hi;
  logic             wr_lo;

  mdu_arith u_arith (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .hi_o (hi_res),
    .lo_o (lo_res)
  );

  // State and counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: issue, count down, commit on 1->0, flush aborts everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    commit  = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && op_valid(op)) begin
            state_d = StBusy;
            cnt_d   = op_lat(op);
            load    = 1'b1;
          end else begin
            wr_hi = mthi;
            wr_lo = mtlo;
          end
        end
        StBusy: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = StIdle;
            commit  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    busy = (state_q == StBusy);
    hi   = hi_q;
    lo   = lo_q;
  end

  // Operand/op capture at issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (load) begin
      a_q  <= src_a;
      b_q  <= src_b;
      op_q <= op;
    end
  end

  // HI/LO: result commit or direct moves from the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end else begin
      if (wr_hi) hi_q <= wdata;
      if (wr_lo) lo_q <= wdata;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
module tb_mdu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mdu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi0;
    logic [31:0] lo0;
    int          lat;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; op = 0; src_a = 0; src_b = 0;
    mthi = 0; mtlo = 0; wdata = 0; flush = 0;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi = 1; wdata = h; tick();
    mthi = 0; mtlo = 1; wdata = l; tick();
    mtlo = 0; wdata = 0;
  endtask

  // Issue one op, count busy cycles (bounded) and return the count.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    start = 1; op = o; src_a = a; src_b = b;
    tick();
    start = 0; op = 0; src_a = 0; src_b = 0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_wr;
  int          m_left;

  function automatic bit m_valid(input logic [2:0] o);
`ifdef MDU_MADD_EN
    return o <= 3'd4;
`else
    return o <= 3'd3;
`endif
  endfunction

  task automatic model_calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] h, input logic [31:0] l,
                            output bit wr, output logic [31:0] nh, output logic [31:0] nl);
    longint sa, sb, q, r;
    longint unsigned ua, ub, u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    wr = 1; nh = h; nl = l;
    case (o)
      3'd0: begin u = longint'(sa * sb); {nh, nl} = u; end
      3'd1: begin u = ua * ub; {nh, nl} = u; end
      3'd2: if (b == 0) wr = 0; else begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      3'd3: if (b == 0) wr = 0; else begin u = ua / ub; nl = u[31:0]; u = ua % ub; nh = u[31:0]; end
      default: begin u = {h, l} + longint'(sa * sb); {nh, nl} = u; end
    endcase
  endtask

  task automatic model_step(input bit s, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input bit wh, input bit wl,
                            input logic [31:0] wd, input bit fl);
    if (fl) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (s && m_valid(o)) begin
      model_calc(o, a, b, m_hi, m_lo, m_wr, m_phi, m_plo);
      m_left = (o == 3'd2 || o == 3'd3) ? 10 : 5;
    end else begin
      if (wh) m_hi = wd;
      if (wl) m_lo = wd;
    end
  endtask

  initial begin
    int n;
    logic [31:0] h0, l0;
    bit          r_s, r_wh, r_wl, r_fl;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b, r_wd;

    vecs.push_back('{"mult_neg1x2", 3'd0, 32'hFFFFFFFF, 32'd2, 32'h1, 32'h2, 5,
                     32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{"div_m7_2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 10,
                     32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"divu_7_2", 3'd3, 32'd7, 32'd2, 32'h0, 32'h0, 10, 32'd1, 32'd3});
    vecs.push_back('{"divu_by0", 3'd3, 32'd9, 32'd0, 32'hAAAA0000, 32'h00005555, 10,
                     32'hAAAA0000, 32'h00005555});
    vecs.push_back('{"div_by0", 3'd2, 32'hFFFFFFF0, 32'd0, 32'h12, 32'h34, 10,
                     32'h12, 32'h34});
    vecs.push_back('{"multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5,
                     32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{"div_min_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h6, 10,
                     32'h0, 32'h80000000});
    vecs.push_back('{"div_7_m2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 10,
                     32'd1, 32'hFFFFFFFD});
`ifdef MDU_MADD_EN
    vecs.push_back('{"madd_3x4", 3'd4, 32'd3, 32'd4, 32'h0, 32'd5, 5, 32'h0, 32'd17});
    vecs.push_back('{"madd_wrap", 3'd4, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 5,
                     32'hFFFFFFFF, 32'hFFFFFFFF});
`endif

    // Reset state.
    idle_inputs();
    reset = 1;
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #2; reset = 0;
    tick();

    // Directed vector table.
    foreach (vecs[i]) begin
      set_hilo(vecs[i].hi0, vecs[i].lo0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check({vecs[i].name, "_lat"}, 64'(n), 64'(vecs[i].lat));
      check({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].ehi});
      check({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].elo});
    end

    // Flush on the 4th busy cycle; mthi during busy and during flush is ignored.
    set_hilo(32'h11, 32'h22);
    start = 1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 0;
    check("flush_busy_on", {63'd0, busy}, 64'd1);
    mthi = 1; wdata = 32'h1234;
    tick(); tick();
    flush = 1;
    tick();
    flush = 0; mthi = 0;
    check("flush_busy_off", {63'd0, busy}, 64'd0);
    check("flush_hi", {32'd0, hi}, 64'h11);
    check("flush_lo", {32'd0, lo}, 64'h22);
    repeat (12) tick();
    check("flush_no_late_hi", {32'd0, hi}, 64'h11);
    mthi = 1; wdata = 32'h1234;
    tick();
    mthi = 0;
    check("mthi_idle", {32'd0, hi}, 64'h1234);

    // Flush in the final busy cycle suppresses the commit.
    set_hilo(32'hA, 32'hB);
    start = 1; op = 3'd0; src_a = 32'd6; src_b = 32'd7;
    tick();
    start = 0;
    repeat (4) tick();
    check("final_flush_still_busy", {63'd0, busy}, 64'd1);
    flush = 1;
    tick();
    flush = 0;
    check("final_flush_busy", {63'd0, busy}, 64'd0);
    check("final_flush_lo", {32'd0, lo}, 64'hB);

    // start wins over mthi in the same idle cycle.
    set_hilo(32'h0, 32'h0);
    mthi = 1; mtlo = 1; wdata = 32'hDEAD;
    run_op(3'd1, 32'd2, 32'd3, n);
    mthi = 0; mtlo = 0;
    check("start_wins_hi", {32'd0, hi}, 64'd0);
    check("start_wins_lo", {32'd0, lo}, 64'd6);

    // Both moves together write both registers.
    mthi = 1; mtlo = 1; wdata = 32'hCAFE;
    tick();
    mthi = 0; mtlo = 0;
    check("mthilo_both", {hi, lo}, {32'hCAFE, 32'hCAFE});

    // Invalid ops are ignored.
    start = 1; op = 3'd5; src_a = 32'd3; src_b = 32'd4;
    tick();
    start = 0;
    check("invalid_op5", {63'd0, busy}, 64'd0);
`ifndef MDU_MADD_EN
    start = 1; op = 3'd4;
    tick();
    start = 0;
    check("madd_disabled", {63'd0, busy}, 64'd0);
    check("madd_disabled_lo", {32'd0, lo}, 64'hCAFE);
`endif

    // Reset between edges mid-mult clears everything immediately; nothing commits later.
    set_hilo(32'h77, 32'h88);
    start = 1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    tick();
    start = 0;
    tick();
    #2; reset = 1; #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #2; reset = 0;
    repeat (8) tick();
    check("rst_no_commit", {31'd0, busy, hi, lo}, 64'd0);

    // Randomized traffic against the model.
    m_hi = 0; m_lo = 0; m_left = 0; m_wr = 0; m_phi = 0; m_plo = 0;
    for (int i = 0; i < 600; i++) begin
      r_s  = ($urandom_range(0, 2) == 0);
      r_op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) r_a = 32'($urandom_range(0, 40)) - 32'd20;
      r_wh = ($urandom_range(0, 7) == 0);
      r_wl = ($urandom_range(0, 7) == 0);
      r_wd = $urandom;
      r_fl = ($urandom_range(0, 24) == 0);
      start = r_s; op = r_op; src_a = r_a; src_b = r_b;
      mthi = r_wh; mtlo = r_wl; wdata = r_wd; flush = r_fl;
      tick();
      model_step(r_s, r_op, r_a, r_b, r_wh, r_wl, r_wd, r_fl);
      check("rnd_busy", {63'd0, busy}, {63'd0, (m_left > 0)});
      check("rnd_hilo", {hi, lo}, {m_hi, m_lo});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
